// File: rtl/alu_op_sequencer.sv
// rtl/alu_op_sequencer.sv - one-command-at-a-time ALU sequencer (INIT/IDLE/LOAD/EXEC/WRITE/RESP)
// Optional divide-by-zero short-circuit: define ALU_OP_SEQUENCER_DIV0_CHECK_EN.
module alu_op_sequencer #(
    parameter int DATA_W     = 32,
    parameter int MUL_CYCLES = 2,
    parameter int DIV_CYCLES = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [3:0]        cmd_op,
    input  logic [DATA_W-1:0] cmd_a,
    input  logic [DATA_W-1:0] cmd_b,
    output logic [DATA_W-1:0] alu_a,
    output logic [DATA_W-1:0] alu_b,
    output logic              ld_a,
    output logic              ld_b,
    output logic              clr_a,
    output logic              clr_b,
    output logic              clr_result,
    output logic              ld_result,
    output logic              flag_wr,
    output logic [12:0]       op_sel,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic              rsp_err,
    output logic              busy
);

`ifdef ALU_OP_SEQUENCER_DIV0_CHECK_EN
    localparam bit DIV0_CHECK = 1'b1;
`else
    localparam bit DIV0_CHECK = 1'b0;
`endif

    localparam logic [3:0] OP_CMP = 4'd2;
    localparam logic [3:0] OP_MUL = 4'd3;
    localparam logic [3:0] OP_DIV = 4'd4;
    localparam logic [3:0] OP_MOD = 4'd5;
    localparam logic [3:0] OP_MAX = 4'd12;

    localparam int MAX_LAT = (DIV_CYCLES > MUL_CYCLES) ? DIV_CYCLES : MUL_CYCLES;
    localparam int CNT_W   = (MAX_LAT > 1) ? $clog2(MAX_LAT) : 1;

    typedef enum logic [2:0] {
        S_INIT,
        S_IDLE,
        S_LOAD,
        S_EXEC,
        S_WRITE,
        S_RESP
    } state_t;

    state_t             state_q, state_d;
    logic [3:0]         op_q, op_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               div0_q, div0_d;
    logic [DATA_W-1:0]  alu_a_q, alu_a_d;
    logic [DATA_W-1:0]  alu_b_q, alu_b_d;
    logic               cmd_ready_q, cmd_ready_d;
    logic               ld_a_q, ld_a_d;
    logic               ld_b_q, ld_b_d;
    logic               clr_a_q, clr_a_d;
    logic               clr_b_q, clr_b_d;
    logic               clr_result_q, clr_result_d;
    logic               ld_result_q, ld_result_d;
    logic               flag_wr_q, flag_wr_d;
    logic [12:0]        op_sel_q, op_sel_d;
    logic               rsp_valid_q, rsp_valid_d;
    logic               rsp_err_q, rsp_err_d;
    logic               busy_q, busy_d;
    logic [12:0]        sel_onehot;

    function automatic logic [CNT_W-1:0] lat_m1(input logic [3:0] op);
        logic [CNT_W-1:0] r;
        r = '0;
        if (op == OP_MUL)
            r = CNT_W'(MUL_CYCLES - 1);
        else if (op == OP_DIV || op == OP_MOD)
            r = CNT_W'(DIV_CYCLES - 1);
        return r;
    endfunction

    always_comb begin
        sel_onehot = 13'd1 << op_q;
    end

    // Outputs are computed alongside the next state so each flop reflects the state it lands in.
    always_comb begin
        state_d      = state_q;
        op_d         = op_q;
        cnt_d        = cnt_q;
        div0_d       = div0_q;
        alu_a_d      = alu_a_q;
        alu_b_d      = alu_b_q;
        rsp_err_d    = rsp_err_q;
        cmd_ready_d  = 1'b0;
        ld_a_d       = 1'b0;
        ld_b_d       = 1'b0;
        clr_a_d      = 1'b0;
        clr_b_d      = 1'b0;
        clr_result_d = 1'b0;
        ld_result_d  = 1'b0;
        flag_wr_d    = 1'b0;
        op_sel_d     = '0;
        rsp_valid_d  = 1'b0;

        case (state_q)
            S_INIT: begin
                // clr_a_q doubles as "clear pulse already issued" so INIT shows one visible clear cycle.
                if (clr_a_q) begin
                    state_d     = S_IDLE;
                    cmd_ready_d = 1'b1;
                end else begin
                    clr_a_d      = 1'b1;
                    clr_b_d      = 1'b1;
                    clr_result_d = 1'b1;
                end
            end
            S_IDLE: begin
                cmd_ready_d = 1'b1;
                if (cmd_valid && cmd_ready_q) begin
                    cmd_ready_d = 1'b0;
                    op_d        = cmd_op;
                    alu_a_d     = cmd_a;
                    alu_b_d     = cmd_b;
                    div0_d      = DIV0_CHECK && (cmd_op == OP_DIV || cmd_op == OP_MOD)
                                  && (cmd_b == '0);
                    if (cmd_op <= OP_MAX) begin
                        state_d   = S_LOAD;
                        ld_a_d    = 1'b1;
                        ld_b_d    = 1'b1;
                        rsp_err_d = 1'b0;
                    end else begin
                        state_d     = S_RESP;
                        rsp_valid_d = 1'b1;
                        rsp_err_d   = 1'b1;
                    end
                end
            end
            S_LOAD: begin
                op_sel_d = sel_onehot;
                if (div0_q) begin
                    state_d      = S_WRITE;
                    clr_result_d = 1'b1;
                    rsp_err_d    = 1'b1;
                end else begin
                    state_d = S_EXEC;
                    cnt_d   = lat_m1(op_q);
                end
            end
            S_EXEC: begin
                op_sel_d = sel_onehot;
                if (cnt_q == '0) begin
                    state_d = S_WRITE;
                    if (op_q == OP_CMP)
                        flag_wr_d = 1'b1;
                    else
                        ld_result_d = 1'b1;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            S_WRITE: begin
                state_d     = S_RESP;
                rsp_valid_d = 1'b1;
            end
            S_RESP: begin
                if (rsp_ready) begin
                    state_d     = S_IDLE;
                    cmd_ready_d = 1'b1;
                    rsp_err_d   = 1'b0;
                end else begin
                    rsp_valid_d = 1'b1;
                end
            end
            default: begin
                state_d = S_INIT;
            end
        endcase

        busy_d = (state_d != S_IDLE) && (state_d != S_INIT);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= S_INIT;
            op_q         <= '0;
            cnt_q        <= '0;
            div0_q       <= 1'b0;
            alu_a_q      <= '0;
            alu_b_q      <= '0;
            cmd_ready_q  <= 1'b0;
            ld_a_q       <= 1'b0;
            ld_b_q       <= 1'b0;
            clr_a_q      <= 1'b0;
            clr_b_q      <= 1'b0;
            clr_result_q <= 1'b0;
            ld_result_q  <= 1'b0;
            flag_wr_q    <= 1'b0;
            op_sel_q     <= '0;
            rsp_valid_q  <= 1'b0;
            rsp_err_q    <= 1'b0;
            busy_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            op_q         <= op_d;
            cnt_q        <= cnt_d;
            div0_q       <= div0_d;
            alu_a_q      <= alu_a_d;
            alu_b_q      <= alu_b_d;
            cmd_ready_q  <= cmd_ready_d;
            ld_a_q       <= ld_a_d;
            ld_b_q       <= ld_b_d;
            clr_a_q      <= clr_a_d;
            clr_b_q      <= clr_b_d;
            clr_result_q <= clr_result_d;
            ld_result_q  <= ld_result_d;
            flag_wr_q    <= flag_wr_d;
            op_sel_q     <= op_sel_d;
            rsp_valid_q  <= rsp_valid_d;
            rsp_err_q    <= rsp_err_d;
            busy_q       <= busy_d;
        end
    end

    assign cmd_ready  = cmd_ready_q;
    assign alu_a      = alu_a_q;
    assign alu_b      = alu_b_q;
    assign ld_a       = ld_a_q;
    assign ld_b       = ld_b_q;
    assign clr_a      = clr_a_q;
    assign clr_b      = clr_b_q;
    assign clr_result = clr_result_q;
    assign ld_result  = ld_result_q;
    assign flag_wr    = flag_wr_q;
    assign op_sel     = op_sel_q;
    assign rsp_valid  = rsp_valid_q;
    assign rsp_err    = rsp_err_q;
    assign busy       = busy_q;

endmodule
